// File: rtl/hamming_decoder_pipe.sv
// Two-stage pipelined Hamming(7,4) decoder with valid/ready on both sides.
// Define HAMMING_ERR_CNT_EN to add the saturating corrected-word counter (err_count, cnt_clr, CNT_W).
module hamming_decoder_pipe
`ifdef HAMMING_ERR_CNT_EN
#(
    parameter int unsigned CNT_W = 8
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] in_code,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_data,
    output logic       out_corrected,
    output logic [2:0] out_syndrome,
    output logic       out_valid,
    input  logic       out_ready
`ifdef HAMMING_ERR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_count
`endif
);

    logic [6:0] s1_code;
    logic       s1_valid;
    logic       adv1;
    logic       adv2;
    logic [2:0] syndrome;
    logic [6:0] flip_mask;
    logic [6:0] fixed_code;

    always_comb begin
        adv2     = !out_valid || out_ready;
        adv1     = !s1_valid || adv2;
        in_ready = adv1;
    end

    // Position k of the codeword lives at bit 7-k.
    always_comb begin
        syndrome[0] = s1_code[6] ^ s1_code[4] ^ s1_code[2] ^ s1_code[0];
        syndrome[1] = s1_code[5] ^ s1_code[4] ^ s1_code[1] ^ s1_code[0];
        syndrome[2] = s1_code[3] ^ s1_code[2] ^ s1_code[1] ^ s1_code[0];
    end

    always_comb begin
        flip_mask = '0;
        if (syndrome != 3'd0) begin
            flip_mask[3'd7 - syndrome] = 1'b1;
        end
        fixed_code = s1_code ^ flip_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_code  <= '0;
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            out_corrected <= 1'b0;
            out_syndrome  <= '0;
            out_valid     <= 1'b0;
        end else if (adv2) begin
            out_data      <= {fixed_code[0], fixed_code[1], fixed_code[2], fixed_code[4]};
            out_corrected <= (syndrome != 3'd0);
            out_syndrome  <= syndrome;
            out_valid     <= s1_valid;
        end
    end

`ifdef HAMMING_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (cnt_clr) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_corrected && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Scoreboard bench for hamming_decoder_pipe; counter checks build only with HAMMING_ERR_CNT_EN.
module tb_hamming_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] in_code;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_corrected;
    logic [2:0] out_syndrome;
    logic       out_valid;
    logic       out_ready;
`ifdef HAMMING_ERR_CNT_EN
    logic       cnt_clr;
    logic [1:0] err_count;
`endif

    always #5 clk = ~clk;

`ifdef HAMMING_ERR_CNT_EN
    hamming_decoder_pipe #(.CNT_W(2)) dut (
`else
    hamming_decoder_pipe dut (
`endif
        .clk(clk), .rst_n(rst_n),
        .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_corrected(out_corrected),
        .out_syndrome(out_syndrome), .out_valid(out_valid), .out_ready(out_ready)
`ifdef HAMMING_ERR_CNT_EN
        , .cnt_clr(cnt_clr), .err_count(err_count)
`endif
    );

    // Hand-encoded codewords for data 0..15 ({d4,d3,d2,d1}).
    localparam logic [6:0] ENC [0:15] = '{
        7'b0000000, 7'b1110000, 7'b1001100, 7'b0111100,
        7'b0101010, 7'b1011010, 7'b1100110, 7'b0010110,
        7'b1101001, 7'b0011001, 7'b0100101, 7'b1010101,
        7'b1000011, 7'b0110011, 7'b0001111, 7'b1111111
    };
    // 7'b1010101 with Hamming position k (1..7) inverted.
    localparam logic [6:0] ERR1 [0:6] = '{
        7'b0010101, 7'b1110101, 7'b1000101, 7'b1011101,
        7'b1010001, 7'b1010111, 7'b1010100
    };

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    logic [7:0] sb [$];
    int pop_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got word %0h, expected none",
                         {out_data, out_corrected, out_syndrome});
            end else begin
                chk("scoreboard", {out_data, out_corrected, out_syndrome}, sb.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [6:0] code, input logic [7:0] exp, output int waits);
        int   n = 0;
        logic acc;
        in_code  = code;
        in_valid = 1'b1;
        waits    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (!acc) waits++;
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: in_ready got 0 for 50 cycles, expected 1");
        end else begin
            sb.push_back(exp);
        end
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int w;
        int wsum;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
`ifdef HAMMING_ERR_CNT_EN
        cnt_clr   = 1'b0;
`endif
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_corrected", out_corrected, 0);
        chk("rst_out_syndrome", out_syndrome, 0);
`ifdef HAMMING_ERR_CNT_EN
        chk("rst_err_count", err_count, 0);
`endif
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean word with latency check
        send(7'b1010101, {4'b1011, 1'b0, 3'd0}, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_early", out_valid, 0);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        chk("clean_data", {out_data, out_corrected, out_syndrome}, {4'b1011, 1'b0, 3'd0});
        drain();

        // Single-bit errors at every position
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) send(ERR1[k], {4'b1011, 1'b1, 3'(k + 1)}, w);
        in_valid = 1'b0;
        drain();

        // Streaming
        @(posedge clk); #1;
        pop_cyc.delete();
        wsum = 0;
        for (int i = 0; i < 16; i++) begin
            send(ENC[i], {4'(i), 1'b0, 3'd0}, w);
            wsum += w;
        end
        in_valid = 1'b0;
        drain();
        chk("stream_waits", wsum, 0);
        chk("stream_count", pop_cyc.size(), 16);
        chk("stream_span", pop_cyc[15] - pop_cyc[0], 15);

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(ENC[3], {4'd3, 1'b0, 3'd0}, w);
        send(ENC[5], {4'd5, 1'b0, 3'd0}, w);
        fork
            send(ENC[9], {4'd9, 1'b0, 3'd0}, w);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold", {out_valid, out_data, out_corrected, out_syndrome},
                        {1'b1, 4'd3, 1'b0, 3'd0});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        chk("bp_waits", w, 3);
        drain();

        // Reset mid-stream
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(ENC[6], {4'd6, 1'b0, 3'd0}, w);
        send(ENC[12], {4'd12, 1'b0, 3'd0}, w);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_data", out_data, 0);
        sb.delete();
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_stale", out_valid, 0);
        @(posedge clk); #1;
        send(ENC[10], {4'd10, 1'b0, 3'd0}, w);
        in_valid = 1'b0;
        drain();

`ifdef HAMMING_ERR_CNT_EN
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_clear", err_count, 0);
        for (int k = 0; k < 5; k++) send(ERR1[k], {4'b1011, 1'b1, 3'(k + 1)}, w);
        in_valid = 1'b0;
        drain();
        chk("cnt_saturate", err_count, 3);

        @(posedge clk); #1;
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        send(ERR1[6], {4'b1011, 1'b1, 3'd7}, w);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cnt_hold_valid", out_valid, 1);
        chk("cnt_hold", err_count, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_clr_priority", err_count, 0);
        chk("cnt_clr_transfer", out_valid, 0);
`endif

        drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
